// File: rtl/ep_filter_pkg.sv
// Shared constants and width helpers for the edge-preserving stream filter.
package ep_filter_pkg;

  localparam int unsigned DefPixW = 8;
  localparam int unsigned DefWin  = 3;
  localparam int unsigned DefWgtW = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned num_taps(input int unsigned win);
    return win * win;
  endfunction

  function automatic int unsigned centre_idx(input int unsigned win);
    return (win * win - 1) / 2;
  endfunction

  function automatic int unsigned wmax(input int unsigned wgt_w);
    return (32'd1 << wgt_w) - 1;
  endfunction

  // Weight-sum width: WGT_W + clog2(N)
  function automatic int unsigned sw_width(input int unsigned wgt_w, input int unsigned win);
    return wgt_w + clog2(num_taps(win));
  endfunction

  // Product-sum width: PIX_W + WGT_W + clog2(N)
  function automatic int unsigned sp_width(input int unsigned pix_w, input int unsigned wgt_w,
                                           input int unsigned win);
    return pix_w + wgt_w + clog2(num_taps(win));
  endfunction

  // Node count at adder-tree level l (pairwise, odd element passes through)
  function automatic int unsigned lvl_cnt(input int unsigned n, input int unsigned l);
    return (n + (32'd1 << l) - 1) >> l;
  endfunction

  // Offset of level l in the flattened adder-tree node array
  function automatic int unsigned lvl_off(input int unsigned n, input int unsigned l);
    int unsigned acc = 0;
    for (int unsigned j = 0; j < l; j++) acc += lvl_cnt(n, j);
    return acc;
  endfunction

endpackage

// File: rtl/ep_div_stage.sv
// One registered restoring-divider stage: produces one quotient bit, MSB first.
// Remaining dividend bits and the growing quotient share one shift register (dq).
module ep_div_stage #(
  parameter int unsigned REM_W = 8,
  parameter int unsigned Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [REM_W-1:0] rem_in,
  input  logic [REM_W-1:0] div_in,
  input  logic [Q_W-1:0]   dq_in,
  output logic [REM_W-1:0] rem_out,
  output logic [REM_W-1:0] div_out,
  output logic [Q_W-1:0]   dq_out
);

  logic [REM_W:0]   trial;
  logic [REM_W-1:0] diff;
  logic             ge;
  logic [REM_W-1:0] rem_q, div_q;
  logic [Q_W-1:0]   dq_q;

  // Trial subtraction; diff is only used when it is known to be < divisor
  always_comb begin
    trial = {rem_in, dq_in[Q_W-1]};
    ge    = (trial >= {1'b0, div_in});
    diff  = trial[REM_W-1:0] - div_in;
  end

  // Stage register, frozen while the pipeline is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      dq_q  <= '0;
    end else if (en) begin
      rem_q <= ge ? diff : trial[REM_W-1:0];
      div_q <= div_in;
      dq_q  <= {dq_in[Q_W-2:0], ge};
    end
  end

  assign rem_out = rem_q;
  assign div_out = div_q;
  assign dq_out  = dq_q;

endmodule

// File: rtl/ep_filter_stream.sv
// Streaming edge-preserving smoothing filter with valid/ready flow control.
// Pipeline: weight reg, product reg, A adder levels, PIX_W divider stages, output reg.
module ep_filter_stream
  import ep_filter_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned WIN   = 3,
  parameter int unsigned WGT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIN*WIN*PIX_W-1:0] in_win,
  input  logic                     in_sof,
  input  logic                     in_eol,
  input  logic [3:0]               thr_shift,
  input  logic                     bypass,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIX_W-1:0]         out_pix,
  output logic                     out_sof,
  output logic                     out_eol
);

  localparam int unsigned N    = num_taps(WIN);
  localparam int unsigned A    = clog2(N);
  localparam int unsigned SW_W = sw_width(WGT_W, WIN);
  localparam int unsigned SP_W = sp_width(PIX_W, WGT_W, WIN);
  localparam int unsigned WMAX = wmax(WGT_W);
  localparam int unsigned CTR  = centre_idx(WIN);
  localparam int unsigned L    = 3 + A + PIX_W;
  localparam int unsigned TOT  = lvl_off(N, A) + 1;
  localparam int unsigned DS   = A + 2;  // pipeline index of the first divider stage

  logic en;
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  logic [PIX_W-1:0] cen;
  logic [PIX_W-1:0] pix_in [N];
  logic [WGT_W-1:0] w_d [N];
  logic [WGT_W-1:0] w_q [N];
  logic [PIX_W-1:0] p_q [N];

  assign cen = in_win[CTR*PIX_W +: PIX_W];

  // Per-tap similarity weight from the shifted absolute difference to the centre
  always_comb begin
    logic [PIX_W-1:0] dif, dsh;
    dif = '0;
    dsh = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pix_in[k] = in_win[k*PIX_W +: PIX_W];
      dif       = (pix_in[k] > cen) ? pix_in[k] - cen : cen - pix_in[k];
      dsh       = dif >> thr_shift;
      w_d[k]    = (32'(dsh) >= WMAX) ? '0 : WGT_W'(WMAX - 32'(dsh));
    end
  end

  // Weight register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        w_q[k] <= '0;
        p_q[k] <= '0;
      end
    end else if (en) begin
      w_q <= w_d;
      p_q <= pix_in;
    end
  end

  // Flattened adder tree: level 0 holds the products, level A the root
  logic [SW_W-1:0] tw_d [TOT];
  logic [SW_W-1:0] tw_q [TOT];
  logic [SP_W-1:0] tp_d [TOT];
  logic [SP_W-1:0] tp_q [TOT];

  // Products and pairwise sums for every tree level
  always_comb begin
    int unsigned src, dst;
    src  = 0;
    dst  = 0;
    tw_d = tw_q;
    tp_d = tp_q;
    for (int unsigned k = 0; k < N; k++) begin
      tw_d[k] = SW_W'(w_q[k]);
      tp_d[k] = SP_W'(w_q[k]) * SP_W'(p_q[k]);
    end
    for (int unsigned l = 1; l <= A; l++) begin
      for (int unsigned i = 0; i < lvl_cnt(N, l); i++) begin
        src = lvl_off(N, l - 1) + 2 * i;
        dst = lvl_off(N, l) + i;
        if (2 * i + 1 < lvl_cnt(N, l - 1)) begin
          tw_d[dst] = tw_q[src] + tw_q[src+1];
          tp_d[dst] = tp_q[src] + tp_q[src+1];
        end else begin
          tw_d[dst] = tw_q[src];
          tp_d[dst] = tp_q[src];
        end
      end
    end
  end

  // Product register and adder-tree level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < TOT; n++) begin
        tw_q[n] <= '0;
        tp_q[n] <= '0;
      end
    end else if (en) begin
      tw_q <= tw_d;
      tp_q <= tp_d;
    end
  end

  // Rounded division: dividend = S_p + S_w/2, divisor = S_w
  logic [SP_W-1:0]  dividend;
  logic             ovf;
  logic [SW_W-1:0]  rem [PIX_W+1];
  logic [SW_W-1:0]  dv  [PIX_W+1];
  logic [PIX_W-1:0] dq  [PIX_W+1];

  assign dividend = tp_q[TOT-1] + SP_W'(tw_q[TOT-1] >> 1);
  assign rem[0]   = dividend[SP_W-1:PIX_W];
  assign dq[0]    = dividend[PIX_W-1:0];
  assign dv[0]    = tw_q[TOT-1];
  // Quotient would not fit in PIX_W bits; cannot happen for a true weighted mean
  assign ovf      = (rem[0] >= dv[0]);

  for (genvar j = 0; j < int'(PIX_W); j++) begin : g_div
    ep_div_stage #(
      .REM_W (SW_W),
      .Q_W   (PIX_W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .rem_in  (rem[j]),
      .div_in  (dv[j]),
      .dq_in   (dq[j]),
      .rem_out (rem[j+1]),
      .div_out (dv[j+1]),
      .dq_out  (dq[j+1])
    );
  end

  // Valid/sideband chain travelling alongside the datapath
  logic             vld_q  [L];
  logic             sof_q  [L];
  logic             eol_q  [L];
  logic             byp_q  [L-1];
  logic             sat_q  [L-1];
  logic [PIX_W-1:0] cpix_q [L-1];
  logic [PIX_W-1:0] out_pix_q;

  // Shift the sideband chain one stage per un-stalled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < L; s++) begin
        vld_q[s] <= 1'b0;
        sof_q[s] <= 1'b0;
        eol_q[s] <= 1'b0;
      end
      for (int unsigned s = 0; s < L - 1; s++) begin
        byp_q[s]  <= 1'b0;
        sat_q[s]  <= 1'b0;
        cpix_q[s] <= '0;
      end
    end else if (en) begin
      vld_q[0]  <= in_valid;
      sof_q[0]  <= in_valid & in_sof;
      eol_q[0]  <= in_valid & in_eol;
      byp_q[0]  <= bypass;
      sat_q[0]  <= 1'b0;
      cpix_q[0] <= cen;
      for (int unsigned s = 1; s < L; s++) begin
        vld_q[s] <= vld_q[s-1];
        sof_q[s] <= sof_q[s-1];
        eol_q[s] <= eol_q[s-1];
      end
      for (int unsigned s = 1; s < L - 1; s++) begin
        byp_q[s]  <= byp_q[s-1];
        sat_q[s]  <= (s == DS) ? ovf : sat_q[s-1];
        cpix_q[s] <= cpix_q[s-1];
      end
    end
  end

  // Output register: bypass, saturate or quotient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pix_q <= '0;
    end else if (en) begin
      if (byp_q[L-2]) begin
        out_pix_q <= cpix_q[L-2];
      end else if (sat_q[L-2]) begin
        out_pix_q <= '1;
      end else begin
        out_pix_q <= dq[PIX_W];
      end
    end
  end

  assign out_valid = vld_q[L-1];
  assign out_sof   = sof_q[L-1];
  assign out_eol   = eol_q[L-1];
  assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_ep_filter_stream.sv
// Directed bench for ep_filter_stream (WIN=3, PIX_W=8, WGT_W=4, latency 15).
module tb_ep_filter_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_win;
  logic        in_sof;
  logic        in_eol;
  logic [3:0]  thr_shift;
  logic        bypass;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pix;
  logic        out_sof;
  logic        out_eol;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ep_filter_stream #(
    .PIX_W (8),
    .WIN   (3),
    .WGT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_win    (in_win),
    .in_sof    (in_sof),
    .in_eol    (in_eol),
    .thr_shift (thr_shift),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  function automatic logic [71:0] mkwin(input logic [7:0] c, input logic [7:0] nb);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = nb;
    w[32 +: 8] = c;
    return w;
  endfunction

  // Behavioural reference: integer weighted mean with round-half-up
  function automatic logic [7:0] ref_pix(input logic [71:0] w, input int thr, input logic byp);
    int c, p, d, wt, sw, sp, q;
    c  = int'(w[32 +: 8]);
    sw = 0;
    sp = 0;
    for (int k = 0; k < 9; k++) begin
      p  = int'(w[k*8 +: 8]);
      d  = (p > c ? p - c : c - p) >> thr;
      wt = 15 - (d > 15 ? 15 : d);
      sw += wt;
      sp += wt * p;
    end
    q = (sp + sw / 2) / sw;
    if (q > 255) q = 255;
    if (byp) q = c;
    return 8'(q);
  endfunction

  // Send one beat into an empty pipeline and wait for its result (no checks here)
  task automatic run_beat(input logic [71:0] w, input logic [3:0] thr, input logic byp,
                          output logic [7:0] pix, output int lat);
    in_win    = w;
    thr_shift = thr;
    bypass    = byp;
    in_sof    = 1'b0;
    in_eol    = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    pix = out_pix;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    in_valid  = 1'b0;
    in_win    = '0;
    in_sof    = 1'b0;
    in_eol    = 1'b0;
    thr_shift = 4'd4;
    bypass    = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_during_valid: got %b want 0", out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++;
    if (out_pix !== 8'd0) begin n_err++; $display("FAIL rst_pix: got %0d want 0", out_pix); end
    n_vec++;
    if (out_sof !== 1'b0) begin n_err++; $display("FAIL rst_sof: got %b want 0", out_sof); end
    n_vec++;
    if (out_eol !== 1'b0) begin n_err++; $display("FAIL rst_eol: got %b want 0", out_eol); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_flat;
    logic [7:0] pix;
    int lat;
    run_beat(mkwin(8'd100, 8'd100), 4'd4, 1'b0, pix, lat);
    n_vec++;
    if (pix !== 8'd100) begin n_err++; $display("FAIL flat_pix: got %0d want 100", pix); end
    n_vec++;
    if (lat != 15) begin n_err++; $display("FAIL flat_latency: got %0d want 15", lat); end
  endtask

  task automatic test_outlier;
    logic [7:0]  pix;
    logic [71:0] w;
    int lat;
    w = mkwin(8'd100, 8'd100);
    w[15:8] = 8'd200;
    run_beat(w, 4'd4, 1'b0, pix, lat);
    n_vec++;
    if (pix !== 8'd107) begin n_err++; $display("FAIL outlier_pix: got %0d want 107", pix); end
  endtask

  task automatic test_edge;
    logic [7:0] pix;
    int lat;
    run_beat(mkwin(8'd0, 8'd255), 4'd4, 1'b0, pix, lat);
    n_vec++;
    if (pix !== 8'd0) begin n_err++; $display("FAIL edge_thr4: got %0d want 0", pix); end
    run_beat(mkwin(8'd0, 8'd255), 4'd8, 1'b0, pix, lat);
    n_vec++;
    if (pix !== 8'd227) begin n_err++; $display("FAIL edge_thr8: got %0d want 227", pix); end
  endtask

  task automatic test_bypass_interleave;
    logic [71:0] wins [6];
    logic [3:0]  thrs [6];
    logic        byps [6];
    logic [7:0]  expp [6];
    logic        exps [6];
    logic        expe [6];
    int          got;
    wins[0] = 72'hAA_BB_CC_DD_25_EE_FF_11_22; thrs[0] = 4'd0;  byps[0] = 1'b1;
    wins[1] = mkwin(8'd100, 8'd100);          thrs[1] = 4'd4;  byps[1] = 1'b0;
    wins[2] = 72'h03_F0_64_C8_25_7B_00_FE_19; thrs[2] = 4'd3;  byps[2] = 1'b1;
    wins[3] = mkwin(8'd100, 8'd100);          thrs[3] = 4'd4;  byps[3] = 1'b0;
    wins[3][15:8] = 8'd200;
    wins[4] = 72'h80_81_82_83_25_10_20_30_40; thrs[4] = 4'd15; byps[4] = 1'b1;
    wins[5] = mkwin(8'd0, 8'd255);            thrs[5] = 4'd8;  byps[5] = 1'b0;
    expp[0] = 8'd37; expp[1] = 8'd100; expp[2] = 8'd37;
    expp[3] = 8'd107; expp[4] = 8'd37; expp[5] = 8'd227;
    exps[0] = 1'b1; exps[1] = 1'b0; exps[2] = 1'b0; exps[3] = 1'b0; exps[4] = 1'b0; exps[5] = 1'b0;
    expe[0] = 1'b0; expe[1] = 1'b0; expe[2] = 1'b1; expe[3] = 1'b0; expe[4] = 1'b0; expe[5] = 1'b1;
    got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        if (got < 6) begin
          n_vec++;
          if (out_pix !== expp[got]) begin
            n_err++; $display("FAIL ilv_pix[%0d]: got %0d want %0d", got, out_pix, expp[got]);
          end
          n_vec++;
          if (out_sof !== exps[got] || out_eol !== expe[got]) begin
            n_err++;
            $display("FAIL ilv_sideband[%0d]: got sof=%b eol=%b want sof=%b eol=%b",
                     got, out_sof, out_eol, exps[got], expe[got]);
          end
          n_vec++;
          if (cyc != 15 + got) begin
            n_err++; $display("FAIL ilv_timing[%0d]: got cycle %0d want %0d", got, cyc, 15 + got);
          end
        end
        got++;
      end
      if (cyc < 6) begin
        in_win    = wins[cyc];
        thr_shift = thrs[cyc];
        bypass    = byps[cyc];
        in_sof    = exps[cyc];
        in_eol    = expe[cyc];
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (got != 6) begin n_err++; $display("FAIL ilv_count: got %0d want 6", got); end
  endtask

  task automatic test_backpressure;
    logic [9:0]  expq [$];
    logic [9:0]  held, expv, obs;
    logic        hold_pend;
    logic [71:0] w;
    int          sent, got, cyc, bad_dup;
    hold_pend = 1'b0;
    held      = '0;
    sent      = 0;
    got       = 0;
    cyc       = 0;
    while (got < 40 && cyc < 3000) begin
      if (sent < 40 && ($urandom % 4 != 0)) begin
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom);
        in_win    = w;
        thr_shift = 4'($urandom_range(0, 6));
        bypass    = ($urandom % 6 == 0);
        in_sof    = 1'($urandom);
        in_eol    = 1'($urandom);
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc >= 30 && cyc < 38) ? 1'b0 : ($urandom % 3 != 0);
      @(negedge clk);
      n_vec++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        n_err++;
        $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, in_ready,
                 ~(out_valid & ~out_ready));
      end
      obs = {out_sof, out_eol, out_pix};
      if (out_valid) begin
        if (hold_pend) begin
          n_vec++;
          if (obs !== held) begin
            n_err++; $display("FAIL bp_hold cyc %0d: got %h want %h", cyc, obs, held);
          end
        end
        if (out_ready) begin
          hold_pend = 1'b0;
          n_vec++;
          if (expq.size() == 0) begin
            n_err++; $display("FAIL bp_extra cyc %0d: got output %h want none", cyc, obs);
          end else begin
            expv = expq.pop_front();
            if (obs !== expv) begin
              n_err++; $display("FAIL bp_data[%0d]: got %h want %h", got, obs, expv);
            end
          end
          got++;
        end else begin
          hold_pend = 1'b1;
          held      = obs;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back({in_sof, in_eol, ref_pix(in_win, int'(thr_shift), bypass)});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (got != 40 || sent != 40 || expq.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got sent=%0d recv=%0d left=%0d want 40/40/0",
               sent, got, expq.size());
    end
    bad_dup = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) bad_dup++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (bad_dup != 0) begin n_err++; $display("FAIL bp_dup: got %0d extra want 0", bad_dup); end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] pix;
    int lat, bad;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_win    = mkwin(8'(20 + 10 * i), 8'(20 + 10 * i));
      thr_shift = 4'd4;
      bypass    = 1'b0;
      in_sof    = 1'b1;
      in_eol    = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_rst_valid[%0d]: got %b want 0", i, out_valid);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad   = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL mid_post_rst: got %0d outputs want 0", bad); end
    run_beat(mkwin(8'd50, 8'd50), 4'd4, 1'b0, pix, lat);
    n_vec++;
    if (pix !== 8'd50) begin n_err++; $display("FAIL mid_first_pix: got %0d want 50", pix); end
    n_vec++;
    if (lat != 15) begin n_err++; $display("FAIL mid_first_lat: got %0d want 15", lat); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_outlier();
    test_edge();
    test_bypass_interleave();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
